smu_seq_matcher: RTL and testbench

//  Multi-stage sequence monitor unit: generalised successor of the single-compare SMU.
//  - Watches a wide observable bus and matches an ordered sequence of up to N per-stage patterns.
//  - Each stage has its own segment select, mask, value and compare op.
//  - Optional inter-stage timeout window.
//  - Emits a registered trigger pulse into the patch/control fabric when the full sequence matches.

---
 rtl/smu_seq_matcher.sv | 205 ++++++++++++++++++++
 tb/tb_smu_seq_matcher.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smu_seq_matcher.sv
// ---------------------------------------------------------------------------
// smu_seq_matcher -- multi-stage sequence monitor unit.
//
// Watches the observable bus obs_i and steps through an ordered sequence of
// up to N per-stage patterns. Each stage selects one SEG-bit segment of the
// bus, masks it and compares it against a masked value using EQ/LT/GT/NE.
// When the last configured stage matches, a registered one-cycle trigger
// pulse is emitted. An optional per-stage timeout returns the sequence to
// stage 0 after cfg_timeout consecutive misses at a stage > 0.
//
// Ports:
//   gated_clk    clock (gated externally with smu_en)
//   reset        synchronous, active-high
//   smu_en       monitor enable; low clears sequence, timer and sticky flag
//   obs_i        [K]       observable bus
//   cfg_seg_sel  [N*SB]    per-stage segment index (>= NSEG reads zero)
//   cfg_mask     [N*SEG]   per-stage compare mask
//   cfg_value    [N*SEG]   per-stage compare value
//   cfg_op       [N*2]     per-stage op: 00 EQ, 01 LT, 10 GT, 11 NE
//   cfg_depth    [SW]      index of last stage (clamped to N-1)
//   cfg_timeout  [TW]      miss cycles allowed at stage > 0; 0 = no timeout
//   cfg_rearm    1 = restart after trigger, 0 = lock until smu_en low
//   smu_state    [SW]      current stage index
//   trigger      one-cycle pulse, full sequence matched
//   trig_sticky  set on any trigger, cleared by reset or smu_en low
//   trig_count   [CW]      saturating trigger count (SMU_TRIG_COUNT_EN only)
//
// Build option: define SMU_TRIG_COUNT_EN to add the trig_count port and its
// saturating counter (cleared only by reset, kept across smu_en low).
// ---------------------------------------------------------------------------
module smu_seq_matcher #(
    parameter int K   = 64,
    parameter int SEG = 32,
    parameter int N   = 4,
    parameter int TW  = 8,
`ifdef SMU_TRIG_COUNT_EN
    parameter int CW  = 16,
`endif
    localparam int NSEG = (K + SEG - 1) / SEG,
    localparam int SB   = (NSEG > 1) ? $clog2(NSEG) : 1,
    localparam int SW   = $clog2(N)
) (
    input  logic              gated_clk,
    input  logic              reset,
    input  logic              smu_en,
    input  logic [K-1:0]      obs_i,
    input  logic [N*SB-1:0]   cfg_seg_sel,
    input  logic [N*SEG-1:0]  cfg_mask,
    input  logic [N*SEG-1:0]  cfg_value,
    input  logic [N*2-1:0]    cfg_op,
    input  logic [SW-1:0]     cfg_depth,
    input  logic [TW-1:0]     cfg_timeout,
    input  logic              cfg_rearm,
    output logic [SW-1:0]     smu_state,
`ifdef SMU_TRIG_COUNT_EN
    output logic [CW-1:0]     trig_count,
`endif
    output logic              trigger,
    output logic              trig_sticky
);

    typedef enum logic [1:0] {IDLE, RUN, LOCKED} fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            trigger_q, trigger_d;
    logic            sticky_q, sticky_d;

    logic [NSEG*SEG-1:0] obs_pad;
    logic [SB-1:0]       cur_sel;
    logic [SEG-1:0]      cur_mask, cur_value, cur_seg, cmp_a, cmp_b;
    logic [1:0]          cur_op;
    logic                hit;
    logic [SW-1:0]       depth_eff;

    // Only non-power-of-2 N can encode a depth beyond the last stage.
    generate
        if ((1 << SW) > N) begin : g_clamp
            assign depth_eff = (cfg_depth > SW'(N - 1)) ? SW'(N - 1) : cfg_depth;
        end else begin : g_noclamp
            assign depth_eff = cfg_depth;
        end
    endgenerate

    // Only the current stage's configuration is ever compared.
    always_comb begin
        cur_sel   = '0;
        cur_mask  = '0;
        cur_value = '0;
        cur_op    = 2'b00;
        for (int s = 0; s < N; s++) begin
            if (stage_q == SW'(s)) begin
                cur_sel   = cfg_seg_sel[s*SB +: SB];
                cur_mask  = cfg_mask[s*SEG +: SEG];
                cur_value = cfg_value[s*SEG +: SEG];
                cur_op    = cfg_op[s*2 +: 2];
            end
        end
    end

    // Zero-pad the bus to whole segments; an out-of-range index matches no
    // segment and therefore reads as zero.
    always_comb begin
        obs_pad        = '0;
        obs_pad[K-1:0] = obs_i;
        cur_seg        = '0;
        for (int g = 0; g < NSEG; g++) begin
            if (cur_sel == SB'(g)) cur_seg = obs_pad[g*SEG +: SEG];
        end
    end

    always_comb begin
        cmp_a = cur_seg & cur_mask;
        cmp_b = cur_value & cur_mask;
        unique case (cur_op)
            2'b00:   hit = (cmp_a == cmp_b);
            2'b01:   hit = (cmp_a <  cmp_b);
            2'b10:   hit = (cmp_a >  cmp_b);
            default: hit = (cmp_a != cmp_b);
        endcase
    end

    always_comb begin
        fsm_d     = fsm_q;
        stage_d   = stage_q;
        timer_d   = timer_q;
        trigger_d = 1'b0;
        sticky_d  = sticky_q;
        if (!smu_en) begin
            fsm_d    = IDLE;
            stage_d  = '0;
            timer_d  = '0;
            sticky_d = 1'b0;
        end else begin
            unique case (fsm_q)
                LOCKED: begin
                    stage_d = '0;
                    timer_d = '0;
                end
                // IDLE evaluates the bus in the same cycle it enters RUN.
                default: begin
                    fsm_d = RUN;
                    if (hit) begin
                        timer_d = '0;
                        if (stage_q == depth_eff) begin
                            trigger_d = 1'b1;
                            sticky_d  = 1'b1;
                            stage_d   = '0;
                            if (!cfg_rearm) fsm_d = LOCKED;
                        end else begin
                            stage_d = stage_q + SW'(1);
                        end
                    end else if (stage_q != '0) begin
                        // timer counts misses already seen; this miss is the
                        // cfg_timeout-th when timer == cfg_timeout-1.
                        if (cfg_timeout != '0 && timer_q == cfg_timeout - TW'(1)) begin
                            stage_d = '0;
                            timer_d = '0;
                        end else if (timer_q != '1) begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge gated_clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            stage_q   <= '0;
            timer_q   <= '0;
            trigger_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            stage_q   <= stage_d;
            timer_q   <= timer_d;
            trigger_q <= trigger_d;
            sticky_q  <= sticky_d;
        end
    end

    assign smu_state   = stage_q;
    assign trigger     = trigger_q;
    assign trig_sticky = sticky_q;

`ifdef SMU_TRIG_COUNT_EN
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (trigger_d && count_q != '1) count_d = count_q + CW'(1);
    end

    always_ff @(posedge gated_clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign trig_count = count_q;
`endif

endmodule

// File: tb/tb_smu_seq_matcher.sv
// Scoreboard bench for smu_seq_matcher. The stimulus process drives inputs on
// the falling edge, steps a behavioural model of the sequence rules and pushes
// the expected post-edge outputs; the monitor pops and compares after every
// rising edge. The DUT is built with K=80/SEG=32 (three segments, the top one
// partly padded, plus an out-of-range index) and N=3 (depth clamping).
module tb_smu_seq_matcher;
    localparam int K = 80, SEG = 32, N = 3, TW = 8, CW = 3;
    localparam int NSEG = 3, SB = 2, SW = 2;

    logic              gated_clk = 1'b0;
    logic              reset, smu_en, cfg_rearm;
    logic [K-1:0]      obs_i;
    logic [N*SB-1:0]   cfg_seg_sel;
    logic [N*SEG-1:0]  cfg_mask, cfg_value;
    logic [N*2-1:0]    cfg_op;
    logic [SW-1:0]     cfg_depth, smu_state;
    logic [TW-1:0]     cfg_timeout;
    logic              trigger, trig_sticky;
`ifdef SMU_TRIG_COUNT_EN
    logic [CW-1:0]     trig_count;
`endif

    smu_seq_matcher #(
        .K(K), .SEG(SEG), .N(N), .TW(TW)
`ifdef SMU_TRIG_COUNT_EN
        , .CW(CW)
`endif
    ) dut (
        .gated_clk(gated_clk), .reset(reset), .smu_en(smu_en), .obs_i(obs_i),
        .cfg_seg_sel(cfg_seg_sel), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
        .cfg_op(cfg_op), .cfg_depth(cfg_depth), .cfg_timeout(cfg_timeout),
        .cfg_rearm(cfg_rearm), .smu_state(smu_state),
`ifdef SMU_TRIG_COUNT_EN
        .trig_count(trig_count),
`endif
        .trigger(trigger), .trig_sticky(trig_sticky)
    );

    always #5 gated_clk = ~gated_clk;

    typedef struct {int stage; bit trig; bit sticky; int count;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    // model state: sequence position, misses seen at this stage, lock flag
    int m_stage = 0, m_miss = 0, m_count = 0;
    bit m_trig = 0, m_sticky = 0, m_locked = 0;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit stage_hit(input int s);
        logic [127:0]   wide;
        logic [SB-1:0]  sel;
        logic [SEG-1:0] seg, a, b;
        logic [1:0]     op;
        sel  = cfg_seg_sel[s*SB +: SB];
        // Bits above K shift in as zero, so indices past the bus read zero.
        wide = 128'(obs_i) >> (int'(sel) * SEG);
        seg  = wide[SEG-1:0];
        a    = seg & cfg_mask[s*SEG +: SEG];
        b    = cfg_value[s*SEG +: SEG] & cfg_mask[s*SEG +: SEG];
        op   = cfg_op[s*2 +: 2];
        case (op)
            2'd0:    return a == b;
            2'd1:    return a < b;
            2'd2:    return a > b;
            default: return a != b;
        endcase
    endfunction

    task automatic model_step();
        exp_t e;
        int   last;
        last = (int'(cfg_depth) > N - 1) ? N - 1 : int'(cfg_depth);
        if (reset) begin
            m_stage = 0; m_miss = 0; m_trig = 0; m_sticky = 0; m_locked = 0; m_count = 0;
        end else if (!smu_en) begin
            m_stage = 0; m_miss = 0; m_trig = 0; m_sticky = 0; m_locked = 0;
        end else if (m_locked) begin
            m_trig = 0; m_stage = 0;
        end else begin
            m_trig = 0;
            if (stage_hit(m_stage)) begin
                m_miss = 0;
                if (m_stage == last) begin
                    m_trig = 1; m_sticky = 1; m_stage = 0;
                    if (m_count < (1 << CW) - 1) m_count++;
                    m_locked = !cfg_rearm;
                end else begin
                    m_stage++;
                end
            end else if (m_stage > 0) begin
                m_miss++;
                if (cfg_timeout != 0 && m_miss == int'(cfg_timeout)) begin
                    m_stage = 0; m_miss = 0;
                end else if (m_miss > (1 << TW) - 1) begin
                    m_miss = (1 << TW) - 1;
                end
            end
        end
        e.stage = m_stage; e.trig = m_trig; e.sticky = m_sticky; e.count = m_count;
        exp_q.push_back(e);
    endtask

    // Inputs currently on the pins are sampled at the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge gated_clk);
        end
    endtask

    task automatic set_stage(input int s, input int sel, input logic [31:0] mask,
                             input logic [31:0] val, input int op);
        cfg_seg_sel[s*SB +: SB] = SB'(sel);
        cfg_mask[s*SEG +: SEG]  = mask;
        cfg_value[s*SEG +: SEG] = val;
        cfg_op[s*2 +: 2]        = 2'(op);
    endtask

    task automatic eq_stages(input int v0, input int v1, input int v2);
        set_stage(0, 0, 32'hFF, 32'(v0), 0);
        set_stage(1, 0, 32'hFF, 32'(v1), 0);
        set_stage(2, 0, 32'hFF, 32'(v2), 0);
    endtask

    task automatic feed(input int v, input int n = 1);
        obs_i = K'(v);
        tick(n);
    endtask

    always begin
        exp_t e;
        @(posedge gated_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("smu_state", longint'(smu_state), longint'(e.stage));
            check("trigger", longint'(trigger), longint'(e.trig));
            check("trig_sticky", longint'(trig_sticky), longint'(e.sticky));
`ifdef SMU_TRIG_COUNT_EN
            check("trig_count", longint'(trig_count), longint'(e.count));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mk;
        reset = 1; smu_en = 0; cfg_rearm = 1; obs_i = '0;
        cfg_seg_sel = '0; cfg_mask = '0; cfg_value = '0; cfg_op = '0;
        cfg_depth = '0; cfg_timeout = '0;
        tick(2);
        reset = 0;

        // T1: single-stage EQ match
        set_stage(0, 0, 32'hFF, 32'h5A, 0);
        smu_en = 1;
        feed(0, 2); feed('h5A); feed(0, 3);

        // T2: three-stage EQ sequence
        smu_en = 0; tick();
        eq_stages(1, 2, 3); cfg_depth = 2; smu_en = 1;
        feed(0); feed(1); feed(2); feed(3); feed(0, 3);

        // T3: timeout fallback, then hit on the last permitted miss cycle
        smu_en = 0; tick();
        eq_stages(1, 2, 0); cfg_depth = 1; cfg_timeout = 3; smu_en = 1;
        feed(1); feed(0, 3); feed(0, 2);
        feed(1); feed(0, 2); feed(2); feed(0, 2);

        // T4: no rearm -> one trigger then locked, smu_en toggle rearms
        smu_en = 0; tick();
        eq_stages('h5A, 0, 0); cfg_depth = 0; cfg_timeout = 0; cfg_rearm = 0; smu_en = 1;
        feed('h5A, 5); feed(0, 2);
        smu_en = 0; tick();
        smu_en = 1; feed('h5A); feed(0, 2);
        cfg_rearm = 1;

        // T5: segment select GT, padded top segment, out-of-range segment
        smu_en = 0; tick();
        set_stage(0, 1, 32'hFFFFFFFF, 32'h10, 2); smu_en = 1;
        obs_i = {16'hFFFF, 32'h11, 32'h0}; tick(2);
        obs_i = {16'hFFFF, 32'h10, 32'h0}; tick();
        cfg_seg_sel[1:0] = 2'd2; tick(2);
        cfg_seg_sel[1:0] = 2'd3; tick(2);

        // T6: reset at stage 2 with the final hit on the pins
        smu_en = 0; tick();
        eq_stages(1, 2, 3); cfg_depth = 2; smu_en = 1;
        feed(1); feed(2); obs_i = K'(3); reset = 1; tick(); reset = 0; feed(0, 2);

        // depth beyond N-1 clamps; long miss run with no timeout never falls back
        smu_en = 0; tick();
        cfg_depth = 3; smu_en = 1;
        feed(1); feed(2); feed(3); feed(0);
        cfg_depth = 1; smu_en = 0; tick(); smu_en = 1;
        feed(1); feed(0, 300); feed(2); feed(0);

        // randomized configurations and traffic
        for (int r = 0; r < 40; r++) begin
            smu_en = 0; tick();
            for (int s = 0; s < N; s++) begin
                case ($urandom_range(0, 3))
                    0: mk = 32'hF;
                    1: mk = 32'h3;
                    2: mk = 32'h0;
                    default: mk = $urandom;
                endcase
                set_stage(s, $urandom_range(0, 3), mk, 32'($urandom_range(0, 3)),
                          $urandom_range(0, 3));
            end
            cfg_depth = SW'($urandom_range(0, 3));
            cfg_timeout = TW'($urandom_range(0, 5));
            cfg_rearm = 1'($urandom_range(0, 1));
            smu_en = 1;
            for (int c = 0; c < 60; c++) begin
                obs_i = {16'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                         32'($urandom_range(0, 3))};
                smu_en = ($urandom_range(0, 99) >= 3);
                reset = ($urandom_range(0, 99) == 0);
                tick();
            end
            reset = 0;
        end

        tick(2);
        if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
